cprv_csr_exec: RTL and testbench
================================

Name: cprv_csr_exec

Overview:
Execution unit for Zicsr instructions (CSRRW/S/C and immediate forms), directly upstream of cprv_csr.
- Accepts one decoded CSR op per handshake.
- Checks privilege and read-only rules, then performs read-modify-write on cprv_csr through its addr/wdata/w_en/rdata port.
- Returns the old CSR value for rd, or an illegal-instruction flag, to the writeback stage.

Parameters:
ADDR_WIDTH, 12, CSR address width
DATA_WIDTH, 64, XLEN / CSR data width

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk
req_valid  in  1  op request valid
req_ready  out  1  unit can accept op
req_funct3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
req_csr_addr  in  ADDR_WIDTH  target CSR
req_rs1_data  in  DATA_WIDTH  rs1 value
req_rs1_idx  in  5  rs1 index; also zimm for immediate forms
req_rd_idx  in  5  destination register
priv_mode  in  2  current privilege (00 U, 01 S, 11 M)
csr_addr  out  ADDR_WIDTH  to cprv_csr addr
csr_wdata  out  DATA_WIDTH  to cprv_csr wdata
csr_w_en  out  1  to cprv_csr w_en
csr_rdata  in  DATA_WIDTH  from cprv_csr rdata; valid the cycle after csr_addr is presented
resp_valid  out  1  result valid
resp_ready  in  1  writeback accepts result
resp_rd_idx  out  5  destination register
resp_rd_data  out  DATA_WIDTH  old CSR value (zero-extended)
resp_rd_we  out  1  write rd (0 if rd==x0 or illegal)
resp_illegal  out  1  raise illegal-instruction exception

Behaviour:
- Reset values (rst_n low at a clock edge):
  - State IDLE; all outputs 0 except req_ready=1.
  - Reset mid-operation aborts the op with no csr_w_en pulse.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: req_ready=1. On req_valid, latch all req_* fields and priv_mode, then evaluate legality.
    - Illegal: go to RESP with resp_illegal=1.
    - Legal: go to READ.
  - READ: csr_addr=latched addr for one cycle. Next edge captures csr_rdata into the old-value register.
    - If a write is required, go to WRITE; otherwise go to RESP.
  - WRITE: csr_w_en=1 for exactly one cycle, with csr_addr and csr_wdata held. Then go to RESP.
  - RESP: resp_valid=1, all resp_* fields stable until resp_ready. On resp_valid && resp_ready, return to IDLE.
- req_ready=0 in every state except IDLE; no back-to-back acceptance.
- Latency: accept edge T0; READ T1; WRITE T2; resp_valid asserted from T3 (T2 with no write, T1 if illegal).
- Operand: src = req_rs1_data for funct3[2]=0; otherwise zero-extend req_rs1_idx to DATA_WIDTH.
- New value:
  - RW: src
  - RS: old | src
  - RC: old & ~src
- Write required:
  - RW/RWI: always.
  - RS/RC/RSI/RCI: only if req_rs1_idx != 0. This checks the index, not the value, so a nonzero-index register holding 0 still writes.
- The read is always performed, including CSRRW with rd=x0. cprv_csr reads have no side effects. resp_rd_we=0 whenever rd==x0.
- Illegal when any of the following holds:
  - funct3 is 000 or 100.
  - csr_addr[9:8] > priv_mode (unsigned compare).
  - csr_addr[11:10]==11 and a write is required.
- On illegal: csr_addr stays 0, csr_w_en never asserted, resp_rd_we=0, resp_rd_data=0.
- csr_addr and csr_wdata read as 0 when not in READ/WRITE. csr_w_en is 0 outside WRITE.
- priv_mode changes after acceptance do not affect the in-flight op.

Decomposition:
- Shared package cprv_csr_pkg holds:
  - funct3 encodings as localparams.
  - Privilege level constants PRIV_U/S/M.
  - The state enum.
  - Function csr_new_value(op, old, src).
- Sub-module cprv_csr_check (combinational): inputs addr, priv, write_req, funct3; output illegal. The FSM stays in the top.

Test Plan:
- M-mode CSRRW addr 0x340, rs1_data 0xDEAD_BEEF, rd=5, CSR holds 0x1234 -> one csr_w_en pulse with wdata 0xDEAD_BEEF at T2; resp rd_data=0x1234, rd_we=1, illegal=0 at T3.
- CSRRS rs1_idx=0, addr 0xF14 (read-only), rd=3, CSR=0x0 -> no csr_w_en, resp at T2 with rd_data=0, illegal=0.
- CSRRCI zimm=0x5, old=0xF -> wdata 0xA; CSRRSI zimm=0x10, old=0xA -> wdata 0x1A.
- U-mode CSRRW addr 0x300 -> resp_illegal=1 at T1, csr_w_en never high, rd_we=0. CSRRW addr 0xC00 from M-mode -> illegal (read-only write).
- resp_ready held 0 for 4 cycles -> resp_* stable and req_ready=0 throughout; accepted on the 5th cycle, req_ready=1 on the next cycle.
- rst_n low during WRITE state -> csr_w_en low from the reset edge, resp_valid=0, req_ready=1; the next op completes normally.

Source files
------------

// File: rtl/cprv_csr_pkg.sv
// Shared definitions for the Zicsr execution unit: funct3 encodings, privilege
// levels, FSM states and the read-modify-write value function.
package cprv_csr_pkg;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam int CSR_MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } csr_state_e;

  // op is funct3[1:0]; register and immediate forms share the same encoding
  function automatic logic [CSR_MAX_W-1:0] csr_new_value(
    input logic [1:0]           op,
    input logic [CSR_MAX_W-1:0] old,
    input logic [CSR_MAX_W-1:0] src
  );
    case (op)
      2'b01:   csr_new_value = src;
      2'b10:   csr_new_value = old | src;
      2'b11:   csr_new_value = old & ~src;
      default: csr_new_value = old;
    endcase
  endfunction

endpackage

// File: rtl/cprv_csr_check.sv
// Combinational legality check for a CSR op: funct3 encoding, privilege level
// and read-only region writes. addr is the top nibble of the CSR address.
module cprv_csr_check
  import cprv_csr_pkg::*;
(
  input  logic [3:0] addr,
  input  logic [1:0] priv,
  input  logic       write_req,
  input  logic [2:0] funct3,
  output logic       illegal
);

  logic bad_funct3;
  logic bad_priv;
  logic bad_ro;

  always_comb begin
    bad_funct3 = !(funct3 inside {F3_RW, F3_RS, F3_RC, F3_RWI, F3_RSI, F3_RCI});
    bad_priv   = addr[1:0] > priv;
    bad_ro     = (addr[3:2] == 2'b11) && write_req;
    illegal    = bad_funct3 || bad_priv || bad_ro;
  end

endmodule

// File: rtl/cprv_csr_exec.sv
// Zicsr execution unit: accepts one decoded CSR op, checks legality, performs
// read-modify-write on cprv_csr and returns the old value to writeback.
module cprv_csr_exec
  import cprv_csr_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_csr_addr,
  input  logic [DATA_WIDTH-1:0] req_rs1_data,
  input  logic [4:0]            req_rs1_idx,
  input  logic [4:0]            req_rd_idx,
  input  logic [1:0]            priv_mode,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  output logic                  csr_w_en,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [4:0]            resp_rd_idx,
  output logic [DATA_WIDTH-1:0] resp_rd_data,
  output logic                  resp_rd_we,
  output logic                  resp_illegal
);

  csr_state_e            state;
  logic [DATA_WIDTH-1:0] lat_src;
  logic [1:0]            lat_op;
  logic                  lat_write;
  logic [4:0]            lat_rd;

  logic [DATA_WIDTH-1:0] req_src;
  logic                  req_write;
  logic                  req_illegal;

  // Set/clear with rs1=x0 never writes; the test is on the index, not the value
  always_comb begin
    req_src   = req_funct3[2] ? DATA_WIDTH'(req_rs1_idx) : req_rs1_data;
    req_write = (req_funct3 == F3_RW) || (req_funct3 == F3_RWI) || (req_rs1_idx != 5'd0);
  end

  cprv_csr_check u_check (
    .addr      (req_csr_addr[ADDR_WIDTH-1 -: 4]),
    .priv      (priv_mode),
    .write_req (req_write),
    .funct3    (req_funct3),
    .illegal   (req_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      req_ready    <= 1'b1;
      csr_addr     <= '0;
      csr_wdata    <= '0;
      csr_w_en     <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rd_idx  <= '0;
      resp_rd_data <= '0;
      resp_rd_we   <= 1'b0;
      resp_illegal <= 1'b0;
      lat_src      <= '0;
      lat_op       <= '0;
      lat_write    <= 1'b0;
      lat_rd       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            lat_src   <= req_src;
            lat_op    <= req_funct3[1:0];
            lat_write <= req_write;
            lat_rd    <= req_rd_idx;
            if (req_illegal) begin
              state        <= ST_RESP;
              resp_valid   <= 1'b1;
              resp_illegal <= 1'b1;
              resp_rd_idx  <= req_rd_idx;
              resp_rd_data <= '0;
              resp_rd_we   <= 1'b0;
            end else begin
              state    <= ST_READ;
              csr_addr <= req_csr_addr;
            end
          end
        end
        ST_READ: begin
          resp_rd_data <= csr_rdata;
          if (lat_write) begin
            state     <= ST_WRITE;
            csr_w_en  <= 1'b1;
            csr_wdata <= DATA_WIDTH'(csr_new_value(lat_op, CSR_MAX_W'(csr_rdata),
                                                   CSR_MAX_W'(lat_src)));
          end else begin
            state        <= ST_RESP;
            csr_addr     <= '0;
            resp_valid   <= 1'b1;
            resp_illegal <= 1'b0;
            resp_rd_idx  <= lat_rd;
            resp_rd_we   <= (lat_rd != 5'd0);
          end
        end
        ST_WRITE: begin
          state        <= ST_RESP;
          csr_w_en     <= 1'b0;
          csr_wdata    <= '0;
          csr_addr     <= '0;
          resp_valid   <= 1'b1;
          resp_illegal <= 1'b0;
          resp_rd_idx  <= lat_rd;
          resp_rd_we   <= (lat_rd != 5'd0);
        end
        ST_RESP: begin
          if (resp_ready) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            resp_valid   <= 1'b0;
            resp_illegal <= 1'b0;
            resp_rd_idx  <= '0;
            resp_rd_data <= '0;
            resp_rd_we   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cprv_csr_exec.sv
// Scoreboard bench for cprv_csr_exec: directed ops push expected responses and
// CSR writes; a monitor pops and compares whenever the DUT presents them.
module tb_cprv_csr_exec;
  import cprv_csr_pkg::*;

  localparam int AW = 12;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_funct3 = '0;
  logic [AW-1:0] req_csr_addr = '0;
  logic [DW-1:0] req_rs1_data = '0;
  logic [4:0]    req_rs1_idx = '0;
  logic [4:0]    req_rd_idx = '0;
  logic [1:0]    priv_mode = PRIV_M;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_wdata;
  logic          csr_w_en;
  logic [DW-1:0] csr_rdata;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [4:0]    resp_rd_idx;
  logic [DW-1:0] resp_rd_data;
  logic          resp_rd_we;
  logic          resp_illegal;

  always #5 clk = ~clk;

  cprv_csr_exec #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_funct3   (req_funct3),
    .req_csr_addr (req_csr_addr),
    .req_rs1_data (req_rs1_data),
    .req_rs1_idx  (req_rs1_idx),
    .req_rd_idx   (req_rd_idx),
    .priv_mode    (priv_mode),
    .csr_addr     (csr_addr),
    .csr_wdata    (csr_wdata),
    .csr_w_en     (csr_w_en),
    .csr_rdata    (csr_rdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rd_idx  (resp_rd_idx),
    .resp_rd_data (resp_rd_data),
    .resp_rd_we   (resp_rd_we),
    .resp_illegal (resp_illegal)
  );

  // CSR file model: combinational read, write on the clock edge
  logic [DW-1:0] csr_mem [4096];
  logic          preload_en = 1'b0;
  logic [AW-1:0] preload_addr = '0;
  logic [DW-1:0] preload_data = '0;

  assign csr_rdata = csr_mem[csr_addr];

  always @(posedge clk) begin
    if (preload_en) csr_mem[preload_addr] <= preload_data;
    else if (csr_w_en) csr_mem[csr_addr] <= csr_wdata;
  end

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
    logic          we;
    logic          ill;
    int            lat;
    int            acc;
  } resp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            acc;
  } wr_t;

  resp_t resp_q[$];
  wr_t   wr_q[$];
  resp_t cur;
  wr_t   wcur;
  bit    seen = 1'b0;
  bit    expect_idle = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: latency is counted in cycles after the accept edge (READ cycle = 1)
  always @(negedge clk) begin
    if (expect_idle) begin
      checkOutput("req_ready_after_resp", 64'(req_ready), 64'(1));
      checkOutput("resp_valid_after_resp", 64'(resp_valid), 64'(0));
      expect_idle = 1'b0;
    end
    if (csr_w_en) begin
      if (wr_q.size() == 0) begin
        checkOutput("unexpected_w_en", 64'(csr_w_en), 64'(0));
      end else begin
        wcur = wr_q.pop_front();
        checkOutput("wr_addr", 64'(csr_addr), 64'(wcur.addr));
        checkOutput("wr_data", csr_wdata, wcur.data);
        checkOutput("wr_cycle", 64'(cyc - wcur.acc + 1), 64'(2));
      end
    end
    if (resp_valid) begin
      if (!seen) begin
        if (resp_q.size() == 0) begin
          checkOutput("unexpected_resp", 64'(resp_valid), 64'(0));
        end else begin
          cur  = resp_q.pop_front();
          seen = 1'b1;
          checkOutput("resp_latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
        end
      end
      if (seen) begin
        checkOutput("resp_rd_idx", 64'(resp_rd_idx), 64'(cur.rd));
        checkOutput("resp_rd_data", resp_rd_data, cur.data);
        checkOutput("resp_rd_we", 64'(resp_rd_we), 64'(cur.we));
        checkOutput("resp_illegal", 64'(resp_illegal), 64'(cur.ill));
      end
      checkOutput("req_ready_busy", 64'(req_ready), 64'(0));
      checkOutput("csr_addr_in_resp", 64'(csr_addr), 64'(0));
      if (resp_ready) begin
        seen        = 1'b0;
        expect_idle = 1'b1;
      end
    end
  end

  task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(posedge clk); #1;
    preload_en   = 1'b1;
    preload_addr = addr;
    preload_data = data;
    @(posedge clk); #1;
    preload_en = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk); #1;
      ok = req_ready;
    end
    if (!ok) checkOutput("wait_req_ready", 64'(req_ready), 64'(1));
  endtask

  // Issue one op; inputs are scrambled after the accept edge to check latching
  task automatic applyStimulus(input logic [2:0] f3, input logic [AW-1:0] addr,
                               input logic [DW-1:0] rs1_data, input logic [4:0] rs1_idx,
                               input logic [4:0] rd, input logic [1:0] priv,
                               input logic [DW-1:0] exp_data, input bit exp_we,
                               input bit exp_ill, input bit exp_wr,
                               input logic [DW-1:0] exp_wdata, input bit push_resp);
    resp_t r;
    wr_t   w;
    waitIdle();
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_csr_addr = addr;
    req_rs1_data = rs1_data;
    req_rs1_idx  = rs1_idx;
    req_rd_idx   = rd;
    priv_mode    = priv;
    @(posedge clk); #1;
    req_valid    = 1'b0;
    priv_mode    = PRIV_U;
    req_rs1_data = ~rs1_data;
    req_rs1_idx  = ~rs1_idx;
    req_rd_idx   = ~rd;
    req_csr_addr = ~addr;
    r.rd   = rd;
    r.data = exp_data;
    r.we   = exp_we;
    r.ill  = exp_ill;
    r.lat  = exp_ill ? 1 : (exp_wr ? 3 : 2);
    r.acc  = cyc;
    if (push_resp) resp_q.push_back(r);
    if (exp_wr) begin
      w.addr = addr;
      w.data = exp_wdata;
      w.acc  = cyc;
      wr_q.push_back(w);
    end
  endtask

  initial begin
    bit hit;
    preload(12'h340, 64'h1234);
    preload(12'hF14, 64'h0);
    preload(12'h341, 64'hF);
    preload(12'hC00, 64'h77);
    preload(12'h100, 64'h55);
    preload(12'h343, 64'h5);
    preload(12'h342, 64'h0);
    checkOutput("rst_req_ready", 64'(req_ready), 64'(1));
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("rst_csr_w_en", 64'(csr_w_en), 64'(0));
    checkOutput("rst_csr_addr", 64'(csr_addr), 64'(0));
    checkOutput("rst_csr_wdata", csr_wdata, 64'(0));
    checkOutput("rst_resp_rd_data", resp_rd_data, 64'(0));
    checkOutput("rst_resp_rd_we", 64'(resp_rd_we), 64'(0));
    checkOutput("rst_resp_illegal", 64'(resp_illegal), 64'(0));
    rst_n = 1'b1;

    //           f3      addr     rs1_data        idx    rd     priv    exp_data        we  ill wr  wdata           push
    applyStimulus(F3_RW,  12'h340, 64'hDEAD_BEEF, 5'd7,  5'd5,  PRIV_M, 64'h1234,       1, 0, 1, 64'hDEAD_BEEF, 1);
    applyStimulus(F3_RS,  12'hF14, 64'h123,       5'd0,  5'd3,  PRIV_M, 64'h0,          1, 0, 0, 64'h0,         1);
    applyStimulus(F3_RCI, 12'h341, 64'hFFFF,      5'd5,  5'd6,  PRIV_M, 64'hF,          1, 0, 1, 64'hA,         1);
    applyStimulus(F3_RSI, 12'h341, 64'h0,         5'h10, 5'd0,  PRIV_M, 64'hA,          0, 0, 1, 64'h1A,        1);
    applyStimulus(F3_RW,  12'h300, 64'h1,         5'd1,  5'd4,  PRIV_U, 64'h0,          0, 1, 0, 64'h0,         1);
    applyStimulus(F3_RW,  12'hC00, 64'h1,         5'd1,  5'd2,  PRIV_M, 64'h0,          0, 1, 0, 64'h0,         1);
    applyStimulus(3'b000, 12'h340, 64'h1,         5'd1,  5'd1,  PRIV_M, 64'h0,          0, 1, 0, 64'h0,         1);
    applyStimulus(3'b100, 12'h340, 64'h1,         5'd1,  5'd1,  PRIV_M, 64'h0,          0, 1, 0, 64'h0,         1);
    applyStimulus(F3_RS,  12'hC00, 64'h0,         5'd9,  5'd7,  PRIV_M, 64'h0,          0, 1, 0, 64'h0,         1);
    applyStimulus(F3_RS,  12'hC00, 64'h0,         5'd0,  5'd7,  PRIV_U, 64'h77,         1, 0, 0, 64'h0,         1);
    applyStimulus(F3_RW,  12'h300, 64'h1,         5'd1,  5'd4,  PRIV_S, 64'h0,          0, 1, 0, 64'h0,         1);
    applyStimulus(F3_RC,  12'h100, 64'h0,         5'd3,  5'd8,  PRIV_S, 64'h55,         1, 0, 1, 64'h55,        1);

    // Writeback stalls for four response cycles, accepts on the fifth
    waitIdle();
    resp_ready = 1'b0;
    applyStimulus(F3_RS,  12'h340, 64'hF0,        5'd2,  5'd9,  PRIV_M, 64'hDEAD_BEEF,  1, 0, 1, 64'hDEAD_BEFF, 1);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #1;
      hit = resp_valid;
    end
    if (!hit) checkOutput("stall_resp_wait", 64'(resp_valid), 64'(1));
    repeat (4) begin @(posedge clk); #1; end
    resp_ready = 1'b1;

    // Reset lands while the op is in WRITE; no response may follow
    applyStimulus(F3_RW,  12'h342, 64'h99,        5'd1,  5'd1,  PRIV_M, 64'h0,          1, 0, 1, 64'h99,        0);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (csr_w_en) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!hit) checkOutput("reset_wait_w_en", 64'(csr_w_en), 64'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_csr_w_en", 64'(csr_w_en), 64'(0));
    checkOutput("abort_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("abort_req_ready", 64'(req_ready), 64'(1));
    rst_n = 1'b1;
    applyStimulus(F3_RW,  12'h343, 64'h6,         5'd2,  5'd1,  PRIV_M, 64'h5,          1, 0, 1, 64'h6,         1);

    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(posedge clk); #1;
      hit = (resp_q.size() == 0) && (wr_q.size() == 0) && !seen && req_ready;
    end
    checkOutput("queues_drained", 64'(resp_q.size() + wr_q.size()), 64'(0));
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
